// File: rtl/bcd_disp_mux3.sv
// 3-digit BCD to 4-digit common-anode 7-segment scanner with a frame-synchronous
// shadow register and leading-zero blanking. The fourth digit slot is always dark.
module bcd_disp_mux3 #(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [2:0] dp_in,
  input  logic       lz_blank,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  logic [N-1:0] q_q, q_d;
  logic [3:0]   d0_q, d1_q, d2_q;
  logic [2:0]   dp_q;
  logic         lz_q;
  logic [3:0]   an_q, an_d;
  logic [7:0]   sseg_q, sseg_d;
  logic         tick_q;
  logic         load;
  logic [1:0]   sel;
  logic [3:0]   dig;
  logic         dp_sel, blank;

  // Active-low gfedcba; non-BCD codes show a dash.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign load = &q_q;
  assign sel  = q_q[N-1:N-2];
  assign q_d  = q_q + N'(1);

  always_comb begin
    dig    = 4'd0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    an_d   = 4'b1111;
    sseg_d = 8'hFF;
    case (sel)
      2'd0: begin
        dig = d0_q; dp_sel = dp_q[0]; an_d = 4'b1110;
      end
      2'd1: begin
        dig = d1_q; dp_sel = dp_q[1]; an_d = 4'b1101;
        blank = lz_q && (d2_q == 4'd0) && (d1_q == 4'd0);
      end
      2'd2: begin
        dig = d2_q; dp_sel = dp_q[2]; an_d = 4'b1011;
        blank = lz_q && (d2_q == 4'd0);
      end
      default: blank = 1'b1;
    endcase
    if (blank) begin
      an_d   = 4'b1111;
      sseg_d = 8'hFF;
    end else begin
      sseg_d = {~dp_sel, seg7(dig)};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      d0_q   <= 4'd0;
      d1_q   <= 4'd0;
      d2_q   <= 4'd0;
      dp_q   <= 3'd0;
      lz_q   <= 1'b0;
      an_q   <= 4'b1111;
      sseg_q <= 8'hFF;
      tick_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      tick_q <= load;
      // Capture once per frame so a value changing mid-scan never tears.
      if (load) begin
        d0_q <= in0;
        d1_q <= in1;
        d2_q <= in2;
        dp_q <= dp_in;
        lz_q <= lz_blank;
      end
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_disp_mux3.sv
// Bench for bcd_disp_mux3 (N=4): a cycle model feeds a scoreboard queue,
// plus directed frame checks taken from the display behaviour.
module tb_bcd_disp_mux3;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] in0 = 4'd0, in1 = 4'd0, in2 = 4'd0;
  logic [2:0] dp_in = 3'd0;
  logic       lz_blank = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int n_vec = 0;
  int n_err = 0;

  bcd_disp_mux3 #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .in0(in0), .in1(in1), .in2(in2),
    .dp_in(dp_in), .lz_blank(lz_blank), .an(an), .sseg(sseg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: segment table and per-slot display rules.
  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  int         mq = 0;
  logic [3:0] md [3] = '{4'd0, 4'd0, 4'd0};
  logic [2:0] mdp = 3'd0;
  logic       mlz = 1'b0;
  logic [12:0] sbq [$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq = 0; md[0] = 0; md[1] = 0; md[2] = 0; mdp = 0; mlz = 0;
      sbq.delete();
    end else begin
      int s;
      logic [3:0] ea;
      logic [7:0] es;
      s  = mq / 4;
      ea = 4'hF;
      es = 8'hFF;
      if (s < 3 && !(mlz && ((s == 2 && md[2] == 0) ||
                             (s == 1 && md[2] == 0 && md[1] == 0)))) begin
        ea = ~(4'b0001 << s);
        es = {~mdp[s], lut[md[s]]};
      end
      sbq.push_back({ea, es, (mq == 15)});
      if (mq == 15) begin
        md[0] = in0; md[1] = in1; md[2] = in2; mdp = dp_in; mlz = lz_blank;
      end
      mq = (mq + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (reset_n && sbq.size() > 0) begin
      logic [12:0] e;
      e = sbq.pop_front();
      chk("sb", {3'd0, an, sseg, frame_tick}, {3'd0, e});
    end
  end

  task automatic wait_tick(output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      cyc++;
      if (frame_tick) seen = 1;
    end
    if (!seen) chk("tick_timeout", 16'd0, 16'd1);
  endtask

  task automatic run_frame(input string tag, input logic [3:0] a0, input logic [7:0] s0,
                           input logic [3:0] a1, input logic [7:0] s1,
                           input logic [3:0] a2, input logic [7:0] s2);
    int c;
    wait_tick(c);
    @(negedge clk); chk({tag, "_s0"}, {4'd0, an, sseg}, {4'd0, a0, s0});
    repeat (3) @(negedge clk);
    @(negedge clk); chk({tag, "_s1"}, {4'd0, an, sseg}, {4'd0, a1, s1});
    repeat (3) @(negedge clk);
    @(negedge clk); chk({tag, "_s2"}, {4'd0, an, sseg}, {4'd0, a2, s2});
    repeat (3) @(negedge clk);
    @(negedge clk); chk({tag, "_s3"}, {4'd0, an, sseg}, 16'h0FFF);
  endtask

  task automatic set_in(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                        input logic [2:0] dp, input logic lz);
    in2 = h; in1 = t; in0 = u; dp_in = dp; lz_blank = lz;
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_sseg", {8'd0, sseg}, 16'h00FF);
    chk("rst_tick", {15'd0, frame_tick}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("f1_s0", {4'd0, an, sseg}, 16'h0EC0);

    set_in(4'd1, 4'd2, 4'd3, 3'b000, 1'b0);
    run_frame("v123", 4'hE, 8'hB0, 4'hD, 8'hA4, 4'hB, 8'hF9);
    wait_tick(c);
    wait_tick(c);
    chk("tick_period", 16'(c), 16'd16);

    set_in(4'd0, 4'd0, 4'd7, 3'b000, 1'b1);
    run_frame("v007lz", 4'hE, 8'hF8, 4'hF, 8'hFF, 4'hF, 8'hFF);
    set_in(4'd0, 4'd0, 4'd7, 3'b000, 1'b0);
    run_frame("v007", 4'hE, 8'hF8, 4'hD, 8'hC0, 4'hB, 8'hC0);
    set_in(4'd1, 4'hC, 4'd0, 3'b000, 1'b0);
    run_frame("v1C0", 4'hE, 8'hC0, 4'hD, 8'hBF, 4'hB, 8'hF9);
    set_in(4'd0, 4'hC, 4'd0, 3'b000, 1'b1);
    run_frame("v0C0lz", 4'hE, 8'hC0, 4'hD, 8'hBF, 4'hF, 8'hFF);
    set_in(4'd4, 4'd5, 4'd6, 3'b010, 1'b0);
    run_frame("v456dp", 4'hE, 8'h82, 4'hD, 8'h12, 4'hB, 8'h99);

    // Mid-frame change must not appear until the next load.
    set_in(4'd1, 4'd2, 4'd3, 3'b000, 1'b0);
    wait_tick(c);
    repeat (5) @(negedge clk);
    set_in(4'd4, 4'd5, 4'd6, 3'b000, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_s2_old", {4'd0, an, sseg}, 16'h0BF9);
    run_frame("mid_new", 4'hE, 8'h82, 4'hD, 8'h92, 4'hB, 8'h99);

    // Asynchronous reset in the middle of a frame.
    wait_tick(c);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an", {12'd0, an}, 16'h000F);
    chk("arst_sseg", {8'd0, sseg}, 16'h00FF);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_f1_s0", {4'd0, an, sseg}, 16'h0EC0);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0)
        set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        in2 = 4'd0;
        if ($urandom_range(0, 1) == 0) in1 = 4'd0;
      end
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
